// File: rtl/approx_mul_pkg.sv
// Shared definitions for the pipelined quadrant-split approximate multiplier.
// Quadrant indices select bits of the per-transaction mode vector.
package approx_mul_pkg;

  localparam int Q_LL = 0;
  localparam int Q_LH = 1;
  localparam int Q_HL = 2;
  localparam int Q_HH = 3;

  typedef logic [3:0] mode_t;

  localparam mode_t MODE_EXACT = 4'b0000;

endpackage

// File: rtl/approx_quad_mul.sv
// One H x H quadrant product, optionally approximated by zeroing its TRUNC LSBs.
// Purely combinational; the parent registers the result.
module approx_quad_mul #(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  logic           approx,
  output logic [2*H-1:0] p
);

  function automatic logic [2*H-1:0] trunc_lsbs(input logic [2*H-1:0] v);
    logic [2*H-1:0] r;
    r = v;
    for (int i = 0; i < TRUNC; i++) r[i] = 1'b0;
    return r;
  endfunction

  logic [2*H-1:0] w_exact;

  assign w_exact = (2*H)'(x) * (2*H)'(y);
  assign p       = approx ? trunc_lsbs(w_exact) : w_exact;

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage valid/ready approximate multiplier: S1 registers four quadrant products,
// S2 registers their shifted sum. Counts accepted beats that requested approximation.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int W     = 8,
  parameter int TRUNC = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  mode_t            mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   prod,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int H  = W / 2;
  localparam int PW = 2 * W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [H-1:0]     w_al, w_ah, w_bl, w_bh;
  logic [2*H-1:0]   w_q_ll, w_q_lh, w_q_hl, w_q_hh;
  logic             w_s1_ready, w_s2_ready, w_accept, w_advance;
  logic [PW-1:0]    w_sum_p1;

  logic [2*H-1:0]   r_q_ll_p1, r_q_lh_p1, r_q_hl_p1, r_q_hh_p1;
  logic             r_vld_p1;
  logic [PW-1:0]    r_prod_p2;
  logic             r_vld_p2;
  logic [CNT_W-1:0] r_cnt;

  assign w_al = a[H-1:0];
  assign w_ah = a[W-1:H];
  assign w_bl = b[H-1:0];
  assign w_bh = b[W-1:H];

  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_q_ll (
    .x(w_al), .y(w_bl), .approx(mode[Q_LL]), .p(w_q_ll)
  );
  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_q_lh (
    .x(w_al), .y(w_bh), .approx(mode[Q_LH]), .p(w_q_lh)
  );
  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_q_hl (
    .x(w_ah), .y(w_bl), .approx(mode[Q_HL]), .p(w_q_hl)
  );
  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_q_hh (
    .x(w_ah), .y(w_bh), .approx(mode[Q_HH]), .p(w_q_hh)
  );

  // Ready chain: a stage can take data if it is empty or its contents move on this edge.
  assign w_s2_ready = !r_vld_p2 || out_ready;
  assign w_s1_ready = !r_vld_p1 || w_s2_ready;
  assign in_ready   = w_s1_ready;
  assign w_accept   = in_valid && w_s1_ready;
  assign w_advance  = r_vld_p1 && w_s2_ready;

  // Stage 1: quadrant products
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_ll_p1 <= w_q_ll;
      r_q_lh_p1 <= w_q_lh;
      r_q_hl_p1 <= w_q_hl;
      r_q_hh_p1 <= w_q_hh;
    end
  end

  assign w_sum_p1 = (PW'(r_q_hh_p1) << W)
                  + ((PW'(r_q_lh_p1) + PW'(r_q_hl_p1)) << H)
                  + PW'(r_q_ll_p1);

  // Stage 2: recombined product; cleared on reset so no stale value is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_prod_p2 <= '0;
    end else begin
      if (w_s2_ready) r_vld_p2 <= r_vld_p1;
      if (w_advance)  r_prod_p2 <= w_sum_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && (mode != MODE_EXACT)) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign out_valid  = r_vld_p2;
  assign prod       = r_prod_p2;
  assign approx_cnt = r_cnt;

endmodule
